// File: rtl/simplez_pkg.sv
// Shared Simplez definitions: RAM geometry, loader frame header and loader state encoding.
package simplez_pkg;

    localparam int unsigned SZ_AW  = 9;
    localparam int unsigned SZ_DW  = 12;
    localparam logic [7:0]  SZ_HDR = 8'h4C;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_LEN_H = 3'd1,
        ST_LEN_L = 3'd2,
        ST_DAT_H = 3'd3,
        ST_DAT_L = 3'd4,
        ST_CSUM  = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_t;

endpackage

// File: rtl/simplez_loader_timeout.sv
// Inter-byte idle counter; expired goes high once TIMEOUT idle cycles have elapsed since the last clear.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 12_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    // Saturating count; clear has priority over enable.
    always_comb begin
        cnt_n = cnt;
        if (clear) begin
            cnt_n = '0;
        end else if (enable && (cnt != CW'(TIMEOUT))) begin
            cnt_n = cnt + CW'(1);
        end
    end

    // Counter and registered expiry flag (flag tracks cnt == TIMEOUT).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            expired <= (cnt_n == CW'(TIMEOUT));
        end
    end

endmodule

// File: rtl/simplez_loader.sv
// Serial program loader: parses HDR/LEN/DATA/CSUM frames from the UART byte stream,
// writes words into program RAM and holds the CPU in reset while loading or after an error.
module simplez_loader
    import simplez_pkg::*;
#(
    parameter int unsigned AW      = SZ_AW,
    parameter int unsigned DW      = SZ_DW,
    parameter int unsigned TIMEOUT = 12_000_000,
    parameter logic [7:0]  HDR     = SZ_HDR
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          err
);

    localparam int unsigned HW = DW - 8;

    ld_state_t     state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [AW-1:0] len, len_n;
    logic          len_hi, len_hi_n;
    logic [HW-1:0] hi, hi_n;
    logic [7:0]    sum, sum_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    logic          we_n, cpu_rstn_n, busy_n, err_n;

    logic          in_frame;
    logic          expired;
    logic [7:0]    sum_add;
    logic [AW-1:0] ptr_inc;
    logic [8:0]    count_rx;

    assign in_frame = (state != ST_RUN) && (state != ST_ERR);
    assign sum_add  = sum + rx_data;
    assign ptr_inc  = ptr + AW'(1);
    assign count_rx = {len_hi, rx_data};

    // Idle timer runs only inside a frame and restarts on every accepted byte.
    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (rx_valid || !in_frame),
        .enable  (in_frame),
        .expired (expired)
    );

    // Frame parser next-state and registered-output logic.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        len_n      = len;
        len_hi_n   = len_hi;
        hi_n       = hi;
        sum_n      = sum;
        addr_n     = mem_addr;
        data_n     = mem_data;
        we_n       = 1'b0;
        cpu_rstn_n = cpu_rstn;
        busy_n     = busy;
        err_n      = err;

        case (state)
            ST_RUN, ST_ERR: begin
                if (state == ST_RUN) begin
                    cpu_rstn_n = 1'b1;
                end
                if (rx_valid && (rx_data == HDR)) begin
                    state_n    = ST_LEN_H;
                    sum_n      = 8'h00;
                    ptr_n      = '0;
                    err_n      = 1'b0;
                    cpu_rstn_n = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            default: begin
                if (rx_valid) begin
                    sum_n = sum_add;
                    case (state)
                        ST_LEN_H: begin
                            if (rx_data[7:1] != 7'd0) begin
                                state_n = ST_ERR;
                            end else begin
                                len_hi_n = rx_data[0];
                                state_n  = ST_LEN_L;
                            end
                        end
                        ST_LEN_L: begin
                            len_n   = AW'(count_rx);
                            state_n = (count_rx == 9'd0) ? ST_CSUM : ST_DAT_H;
                        end
                        ST_DAT_H: begin
                            if ((rx_data >> HW) != 8'd0) begin
                                state_n = ST_ERR;
                            end else begin
                                hi_n    = rx_data[HW-1:0];
                                state_n = ST_DAT_L;
                            end
                        end
                        ST_DAT_L: begin
                            addr_n  = ptr;
                            data_n  = {hi, rx_data};
                            we_n    = 1'b1;
                            ptr_n   = ptr_inc;
                            state_n = (ptr_inc == len) ? ST_CSUM : ST_DAT_H;
                        end
                        ST_CSUM: begin
                            if (rx_data == sum) begin
                                state_n    = ST_RUN;
                                cpu_rstn_n = 1'b1;
                                busy_n     = 1'b0;
                            end else begin
                                state_n = ST_ERR;
                            end
                        end
                        default: begin
                            state_n = ST_ERR;
                        end
                    endcase
                end else if (expired) begin
                    state_n = ST_ERR;
                end

                // Any abort path: flag it, drop busy, keep the CPU halted.
                if (state_n == ST_ERR) begin
                    err_n      = 1'b1;
                    busy_n     = 1'b0;
                    cpu_rstn_n = 1'b0;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_RUN;
            ptr      <= '0;
            len      <= '0;
            len_hi   <= 1'b0;
            hi       <= '0;
            sum      <= 8'h00;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            cpu_rstn <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            len      <= len_n;
            len_hi   <= len_hi_n;
            hi       <= hi_n;
            sum      <= sum_n;
            mem_addr <= addr_n;
            mem_data <= data_n;
            mem_we   <= we_n;
            cpu_rstn <= cpu_rstn_n;
            busy     <= busy_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_simplez_loader.sv
// Directed self-checking bench for simplez_loader (TIMEOUT shortened to 100 cycles).
module tb_simplez_loader;

    logic        clk;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [8:0]  mem_addr;
    logic [11:0] mem_data;
    logic        mem_we;
    logic        cpu_rstn;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int wcnt   = 0;
    int wbase;

    simplez_loader #(
        .AW      (9),
        .DW      (12),
        .TIMEOUT (100),
        .HDR     (8'h4C)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes (value sampled before the edge updates it).
    always @(posedge clk) begin
        if (mem_we === 1'b1) wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte for one cycle; returns on the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstn     = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // Reset
        idle(5);
        chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_we",       32'(mem_we),   32'd0);
        chk("rst_addr",     32'(mem_addr), 32'd0);
        chk("rst_data",     32'(mem_data), 32'd0);
        rstn = 1'b1;
        idle(1);
        chk("rel_cpu_rstn", 32'(cpu_rstn), 32'd1);

        // Good load: 4C 00 02 01 23 0F FF 34
        wbase = wcnt;
        send(8'h4C);
        chk("good_hdr_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("good_hdr_busy",     32'(busy),     32'd1);
        send(8'h00);
        send(8'h02);
        send(8'h01);
        chk("good_dath_no_we", 32'(mem_we), 32'd0);
        send(8'h23);
        chk("good_w0_we",   32'(mem_we),   32'd1);
        chk("good_w0_addr", 32'(mem_addr), 32'h000);
        chk("good_w0_data", 32'(mem_data), 32'h123);
        idle(1);
        chk("good_w0_pulse", 32'(mem_we), 32'd0);
        send(8'h0F);
        send(8'hFF);
        chk("good_w1_we",   32'(mem_we),   32'd1);
        chk("good_w1_addr", 32'(mem_addr), 32'h001);
        chk("good_w1_data", 32'(mem_data), 32'hFFF);
        chk("good_pre_csum_cpu", 32'(cpu_rstn), 32'd0);
        send(8'h34);
        chk("good_cpu_rstn", 32'(cpu_rstn), 32'd1);
        chk("good_busy",     32'(busy),     32'd0);
        chk("good_err",      32'(err),      32'd0);
        idle(1);
        chk("good_wcnt", 32'(wcnt - wbase), 32'd2);

        // Bad checksum
        wbase = wcnt;
        send(8'h4C); send(8'h00); send(8'h02);
        send(8'h01); send(8'h23); send(8'h0F); send(8'hFF);
        send(8'h35);
        chk("badcs_err",      32'(err),      32'd1);
        chk("badcs_busy",     32'(busy),     32'd0);
        chk("badcs_cpu_rstn", 32'(cpu_rstn), 32'd0);
        idle(5);
        chk("badcs_cpu_held", 32'(cpu_rstn), 32'd0);
        chk("badcs_wcnt", 32'(wcnt - wbase), 32'd2);
        send(8'h4C);
        chk("recover_err_clr", 32'(err),  32'd0);
        chk("recover_busy",    32'(busy), 32'd1);
        send(8'h00); send(8'h02);
        send(8'h01); send(8'h23); send(8'h0F); send(8'hFF);
        send(8'h34);
        chk("recover_cpu_rstn", 32'(cpu_rstn), 32'd1);
        chk("recover_err",      32'(err),      32'd0);

        // Empty image, then stray bytes in RUN
        wbase = wcnt;
        send(8'h4C); send(8'h00); send(8'h00); send(8'h00);
        chk("empty_cpu_rstn", 32'(cpu_rstn), 32'd1);
        chk("empty_err",      32'(err),      32'd0);
        chk("empty_busy",     32'(busy),     32'd0);
        send(8'h55); send(8'hAA);
        idle(2);
        chk("stray_cpu_rstn", 32'(cpu_rstn), 32'd1);
        chk("stray_busy",     32'(busy),     32'd0);
        chk("empty_stray_wcnt", 32'(wcnt - wbase), 32'd0);

        // Framing errors
        send(8'h4C); send(8'h02);
        chk("lenh_err",      32'(err),      32'd1);
        chk("lenh_busy",     32'(busy),     32'd0);
        chk("lenh_cpu_rstn", 32'(cpu_rstn), 32'd0);
        wbase = wcnt;
        send(8'h4C); send(8'h00); send(8'h01); send(8'h1F);
        chk("dath_err", 32'(err), 32'd1);
        send(8'h23);
        idle(2);
        chk("dath_no_we", 32'(wcnt - wbase), 32'd0);
        chk("dath_err_ignore", 32'(err), 32'd1);

        // HDR value inside a frame is data: word 0x04C, csum 00+01+00+4C = 4D
        send(8'h4C); send(8'h00); send(8'h01); send(8'h00); send(8'h4C);
        chk("hdr_data_we",   32'(mem_we),   32'd1);
        chk("hdr_data_word", 32'(mem_data), 32'h04C);
        chk("hdr_data_busy", 32'(busy),     32'd1);
        send(8'h4D);
        chk("hdr_data_cpu_rstn", 32'(cpu_rstn), 32'd1);

        // Timeout: a byte 99 cycles after the last one restarts the counter
        send(8'h4C); send(8'h00); send(8'h01);
        idle(98);
        chk("to_pre_err", 32'(err), 32'd0);
        send(8'h00);
        chk("to_restart_busy", 32'(busy), 32'd1);
        idle(95);
        chk("to_mid_err",  32'(err),  32'd0);
        chk("to_mid_busy", 32'(busy), 32'd1);
        idle(8);
        chk("to_err",      32'(err),      32'd1);
        chk("to_busy",     32'(busy),     32'd0);
        chk("to_cpu_rstn", 32'(cpu_rstn), 32'd0);

        // Reset mid-frame aborts without a write; CPU released after release
        send(8'h4C); send(8'h00); send(8'h01); send(8'h01);
        wbase = wcnt;
        @(negedge clk);
        rstn     = 1'b0;
        rx_data  = 8'h23;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("midrst_busy",     32'(busy),     32'd0);
        chk("midrst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("midrst_err",      32'(err),      32'd0);
        rstn = 1'b1;
        idle(1);
        chk("midrst_rel_cpu", 32'(cpu_rstn), 32'd1);
        idle(1);
        chk("midrst_no_we", 32'(wcnt - wbase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
